pipe_hazard_arbiter: RTL

- Parametrised successor to the fixed-table pipeline stall/flush controller.
- Takes N_REQ hazard/stall request sources and drives per-stage stall and flush vectors for an N_STAGE pipeline. Stage bit 0 is the PC.
- Priority is by source index; the higher index wins, so later pipeline stages win.
- Adds sequential behaviour the combinational version lacks:
  - a post-reset flush sequence;
  - pending capture of one-cycle (pulse) requests that lose arbitration;
  - a stall watchdog.

---
 rtl/pipe_hazard_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_hazard_arbiter                                        |
// | Description : Parametrised pipeline stall/flush arbiter. The highest-    |
// |               index active request source wins and drives its stall and  |
// |               flush vectors. Adds a post-reset flush phase, pending      |
// |               capture of losing pulse requests and a stall watchdog.     |
// |               Optional macro PIPE_HAZARD_PERF_EN adds per-source win     |
// |               counters with a selectable read port. Requires N_REQ >= 2. |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
module pipe_hazard_arbiter #(
  parameter int                         N_STAGE       = 6,
  parameter int                         N_REQ         = 8,
  parameter logic [N_REQ*N_STAGE-1:0]   STALL_MASK    = '0,
  parameter logic [N_REQ*N_STAGE-1:0]   FLUSH_MASK    = '0,
  parameter logic [N_REQ-1:0]           PULSE_MASK    = '0,
  parameter int                         RST_FLUSH_CYC = 2,
  parameter int                         CNT_W         = 8,
  parameter int                         TIMEOUT       = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_i,
  input  logic                       kill_i,
`ifdef PIPE_HAZARD_PERF_EN
  input  logic [$clog2(N_REQ)-1:0]   perf_sel_i,
  output logic [31:0]                perf_cnt_o,
`endif
  output logic [N_STAGE-1:0]         stall_o,
  output logic [N_STAGE-1:0]         flush_o,
  output logic                       win_valid_o,
  output logic [$clog2(N_REQ)-1:0]   win_id_o,
  output logic                       timeout_o
);

  localparam int                 c_id_w    = $clog2(N_REQ);
  localparam logic [3:0]         c_rf_init = 4'(RST_FLUSH_CYC);
  localparam logic [CNT_W-1:0]   c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   c_cnt_max = '1;

  logic [3:0]          r_rf_cnt;
  logic [N_REQ-1:0]    r_pending;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic [N_REQ-1:0]    w_eff;
  logic                w_any;
  logic [c_id_w-1:0]   w_win;
  logic [N_STAGE-1:0]  w_sel_stall;
  logic [N_STAGE-1:0]  w_sel_flush;
  logic                w_hold;
  logic [N_REQ-1:0]    w_pending_nxt;

  // Live requests plus remembered pulses; outputs are forced during reset and the flush phase.
  assign w_eff  = req_i | r_pending;
  assign w_hold = rst || (r_rf_cnt != 4'd0);

  // Priority encode: a later (higher) index overwrites, so the highest active source wins.
  always_comb begin
    w_any       = 1'b0;
    w_win       = '0;
    w_sel_stall = '0;
    w_sel_flush = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_eff[i]) begin
        w_any       = 1'b1;
        w_win       = c_id_w'(i);
        w_sel_stall = STALL_MASK[i*N_STAGE +: N_STAGE];
        w_sel_flush = FLUSH_MASK[i*N_STAGE +: N_STAGE];
      end
    end
  end

  // Output drive: full flush with no winner while held, otherwise only the winner's masks.
  always_comb begin
    stall_o     = '0;
    flush_o     = '1;
    win_valid_o = 1'b0;
    win_id_o    = '0;
    if (!w_hold) begin
      stall_o     = w_sel_stall;
      flush_o     = w_sel_flush;
      win_valid_o = w_any;
      win_id_o    = w_win;
    end
  end

  // Next pending: a winner clears its bit, a losing pulse sets it, kill wipes everything.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_valid_o && (w_win == c_id_w'(i))) begin
        w_pending_nxt[i] = 1'b0;
      end else if (PULSE_MASK[i] && req_i[i]) begin
        w_pending_nxt[i] = 1'b1;
      end
    end
    if (kill_i) begin
      w_pending_nxt = '0;
    end
  end

  // Pending pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Post-reset flush countdown; reloads on every reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_cnt <= c_rf_init;
    end else if (r_rf_cnt != 4'd0) begin
      r_rf_cnt <= r_rf_cnt - 4'd1;
    end
  end

  // Watchdog: counts consecutive PC-stall cycles, saturating, cleared by any non-stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o[0]) begin
      if (r_stall_cnt != c_cnt_max) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end else begin
      r_stall_cnt <= '0;
    end
  end

  // Timeout comes from the registered count only; masked while reset is asserted.
  assign timeout_o = !rst && (r_stall_cnt >= c_timeout);

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_perf_cnt [N_REQ];

  // Per-source win counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        r_perf_cnt[i] <= '0;
      end else if (win_valid_o && (w_win == c_id_w'(i))) begin
        r_perf_cnt[i] <= r_perf_cnt[i] + 32'd1;
      end
    end
  end

  // Combinational read; selects beyond N_REQ read as zero.
  always_comb begin
    perf_cnt_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (perf_sel_i == c_id_w'(i)) begin
        perf_cnt_o = r_perf_cnt[i];
      end
    end
  end
`endif

endmodule
`default_nettype wire
